random_descrambler: RTL and testbench

- Inverse of the number scrambler: takes a 10-bit scrambled code and the 4-bit rotation key that produced it, and recovers the original 10-bit number.
- Descramble order: rotate right by the key, then apply the inverse of the fixed bit permutation.
- Sits between the scrambled-number source and game-check logic, with a valid/ready handshake on both sides.
- Rotation is iterative, one bit per clock, so latency depends on the key.

---
 rtl/random_descrambler.sv | 136 +++++++++++++
 tb/tb_random_descrambler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/random_descrambler.sv
// random_descrambler: recovers a 10-bit number from its scrambled code and
// rotation key. Descramble is rotate-right by key, then inverse permutation.
// Default build rotates one bit per clock (latency key+1). Defining
// RANDOM_DESCR_FAST_EN swaps in a combinational barrel rotate on the accept
// edge, so every word (legal or not) reaches OUT with latency 0.
module random_descrambler #(
   parameter int W    = 10,
   parameter int KW   = 4,
   parameter int KMAX = 9
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [W-1:0]  i_code,
   input  logic [KW-1:0] i_key,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [W-1:0]  o_num,
   output logic          o_err
);

   localparam logic [KW-1:0] KMAX_K = KW'(KMAX);

   typedef enum logic [1:0] {S_IDLE, S_ROT, S_OUT} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  num_q, num_d;
   logic          err_q, err_d;
   logic          valid_q, valid_d;
`ifndef RANDOM_DESCR_FAST_EN
   logic [W-1:0]  sh_q, sh_d;
   logic [KW-1:0] cnt_q, cnt_d;
`endif

   // Inverse of the scrambler's fixed bit permutation (W is fixed at 10).
   function automatic logic [W-1:0] invperm(input logic [W-1:0] m);
      invperm = {m[6], m[3], m[7], m[1], m[2], m[0], m[8], m[5], m[9], m[4]};
   endfunction

`ifdef RANDOM_DESCR_FAST_EN
   // Barrel rotate right; keys above KMAX never reach here.
   function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input logic [KW-1:0] k);
      logic [2*W-1:0] t;
      t    = {v, v} >> k;
      rotr = t[W-1:0];
   endfunction
`endif

   // Next-state and datapath: accept in IDLE, rotate in ROT, hold in OUT.
   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      err_d   = err_q;
      valid_d = valid_q;
`ifndef RANDOM_DESCR_FAST_EN
      sh_d    = sh_q;
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
`ifndef RANDOM_DESCR_FAST_EN
               sh_d  = i_code;
               cnt_d = i_key;
`endif
               if (i_key > KMAX_K) begin
                  num_d   = '0;
                  err_d   = 1'b1;
                  valid_d = 1'b1;
                  state_d = S_OUT;
               end else begin
`ifdef RANDOM_DESCR_FAST_EN
                  num_d   = invperm(rotr(i_code, i_key));
                  err_d   = 1'b0;
                  valid_d = 1'b1;
                  state_d = S_OUT;
`else
                  state_d = S_ROT;
`endif
               end
            end
         end
`ifndef RANDOM_DESCR_FAST_EN
         S_ROT: begin
            if (cnt_q != '0) begin
               sh_d  = {sh_q[0], sh_q[W-1:1]};
               cnt_d = cnt_q - KW'(1);
            end else begin
               num_d   = invperm(sh_q);
               err_d   = 1'b0;
               valid_d = 1'b1;
               state_d = S_OUT;
            end
         end
`endif
         S_OUT: begin
            // Ready comes back only in IDLE, so no accept overlaps this handshake.
            if (i_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         num_q   <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
`ifndef RANDOM_DESCR_FAST_EN
         sh_q    <= '0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         err_q   <= err_d;
         valid_q <= valid_d;
`ifndef RANDOM_DESCR_FAST_EN
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign o_ready = (state_q == S_IDLE);
   assign o_valid = valid_q;
   assign o_num   = num_q;
   assign o_err   = err_q;

endmodule

// File: tb/tb_random_descrambler.sv
// Bench for random_descrambler: directed words with hand-computed results,
// plus a cycle-level model (latency countdown + arithmetic descramble)
// compared against the DUT on every falling edge.
module tb_random_descrambler;

`ifdef RANDOM_DESCR_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst_n, i_valid, i_ready;
   logic [9:0] i_code;
   logic [3:0] i_key;
   logic       o_ready, o_valid, o_err;
   logic [9:0] o_num;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   random_descrambler dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_code(i_code), .i_key(i_key), .o_valid(o_valid), .i_ready(i_ready),
      .o_num(o_num), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: descramble with plain arithmetic, timing as a latency countdown.
   int  src[10] = '{4, 9, 5, 8, 0, 2, 1, 7, 3, 6};
   bit  m_busy, m_valid, m_err;
   int  m_wait, m_num, m_pend;

   function automatic int descr(input int code, input int k);
      int m, r;
      m = ((code >> k) | (code << (10 - k))) & 'h3FF;
      r = 0;
      for (int i = 0; i < 10; i++) r |= ((m >> src[i]) & 1) << i;
      return r;
   endfunction

   function automatic int lat_of(input int k);
      if (k > 9 || FAST) return 0;
      return k + 1;
   endfunction

   always @(posedge i_clk) begin
      if (!i_rst_n) begin
         m_busy = 0; m_valid = 0; m_err = 0; m_num = 0; m_wait = 0;
      end else if (m_valid) begin
         if (i_ready) m_valid = 0;
      end else if (m_busy) begin
         m_wait--;
         if (m_wait == 0) begin
            m_busy = 0; m_valid = 1; m_num = m_pend; m_err = 0;
         end
      end else if (i_valid) begin
         if (i_key > 9) begin
            m_valid = 1; m_err = 1; m_num = 0;
         end else if (lat_of(i_key) == 0) begin
            m_valid = 1; m_err = 0; m_num = descr(i_code, i_key);
         end else begin
            m_busy = 1; m_wait = lat_of(i_key); m_pend = descr(i_code, i_key);
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge i_clk) begin
      if (chk_en) begin
         chk("model_ready", int'(o_ready), int'(!m_busy && !m_valid));
         chk("model_valid", int'(o_valid), int'(m_valid));
         if (m_valid) begin
            chk("model_num", int'(o_num), m_num);
            chk("model_err", int'(o_err), int'(m_err));
         end
      end
   end

   // One word: offer at a falling edge, measure latency, optional backpressure.
   task automatic xfer(input logic [9:0] code, input logic [3:0] key, input int lat_exp,
                       input logic [9:0] num_exp, input logic err_exp, input int hold);
      int lat;
      i_code = code; i_key = key; i_valid = 1'b1; i_ready = (hold == 0);
      chk("ready_idle", int'(o_ready), 1);
      @(negedge i_clk);
      i_valid = 1'b0; i_code = 10'h3C5; i_key = 4'hA;
      chk("ready_busy", int'(o_ready), 0);
      lat = 0;
      while (!o_valid && lat < 40) begin
         @(negedge i_clk);
         lat++;
      end
      chk("latency", lat, lat_exp);
      chk("num", int'(o_num), int'(num_exp));
      chk("err", int'(o_err), int'(err_exp));
      for (int i = 0; i < hold; i++) begin
         @(negedge i_clk);
         chk("hold_valid", int'(o_valid), 1);
         chk("hold_num", int'(o_num), int'(num_exp));
         chk("hold_err", int'(o_err), int'(err_exp));
         chk("hold_ready", int'(o_ready), 0);
      end
      i_ready = 1'b1;
      @(negedge i_clk);
      chk("drop_valid", int'(o_valid), 0);
      chk("ready_back", int'(o_ready), 1);
      i_ready = 1'b0;
   endtask

   initial begin
      i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_code = '0; i_key = '0;
      repeat (2) @(negedge i_clk);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_ready", int'(o_ready), 1);
      chk("rst_num", int'(o_num), 0);
      chk("rst_err", int'(o_err), 0);
      // Pin the model itself against hand-computed values.
      chk("model_pin_a", descr('h080, 3), 'h001);
      chk("model_pin_b", descr('h008, 9), 'h001);
      chk("model_pin_c", descr('h001, 2), 'h008);
      chk_en = 1'b1;
      i_rst_n = 1'b1;

      xfer(10'h080, 4'd3,  lat_of(3),  10'h001, 1'b0, 0);
      xfer(10'h040, 4'd0,  lat_of(0),  10'h200, 1'b0, 0);
      xfer(10'h008, 4'd9,  lat_of(9),  10'h001, 1'b0, 0);
      xfer(10'h155, 4'd12, 0,          10'h000, 1'b1, 0);
      xfer(10'h001, 4'd2,  lat_of(2),  10'h008, 1'b0, 0);
      xfer(10'h080, 4'd3,  lat_of(3),  10'h001, 1'b0, 5);
      xfer(10'h2AA, 4'd15, 0,          10'h000, 1'b1, 2);
      xfer(10'h3FF, 4'd4,  lat_of(4),  10'h3FF, 1'b0, 1);

      // Reset while the key-7 word is in flight: nothing may come out.
      i_code = 10'h123; i_key = 4'd7; i_valid = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      chk("midrst_valid", int'(o_valid), 0);
      chk("midrst_num", int'(o_num), 0);
      chk("midrst_err", int'(o_err), 0);
      chk("midrst_ready", int'(o_ready), 1);
      i_rst_n = 1'b1;
      repeat (12) begin
         @(negedge i_clk);
         chk("no_stale", int'(o_valid), 0);
      end
      xfer(10'h040, 4'd0, lat_of(0), 10'h200, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
